cube_regbus_arbiter: RTL
========================

Name: cube_regbus_arbiter

Overview:
- Two-requester AXI4-Lite master arbiter that shares the cube renderer controller's register slave port (S00_AXI) between two on-chip register clients, e.g. a scene sequencer and a debug/host bridge.
- Each requester issues single-beat read or write commands over a simple valid/ready interface.
- The block grants one requester at a time (round-robin) and runs exactly one AXI4-Lite transaction to completion.
- It then returns the read data and response to the requester that issued the command.

Parameters:
ADDR_WIDTH, 32, AXI and requester address width.
DATA_WIDTH, 32, AXI and requester data width (32 only). WSTRB width is DATA_WIDTH/8.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
reqN_valid (N=0,1)  in  1  command valid.
reqN_ready (N=0,1)  out  1  command accepted this cycle.
reqN_wr (N=0,1)  in  1  1 = write, 0 = read.
reqN_addr (N=0,1)  in  ADDR_WIDTH  byte address.
reqN_wdata (N=0,1)  in  DATA_WIDTH  write data.
reqN_wstrb (N=0,1)  in  DATA_WIDTH/8  byte strobes.
rspN_valid (N=0,1)  out  1  one-cycle completion pulse.
rspN_rdata (N=0,1)  out  DATA_WIDTH  read data; 0 for writes.
rspN_resp (N=0,1)  out  2  AXI RRESP or BRESP.
M_AXI_AWADDR / AWPROT / AWVALID  out  ADDR_WIDTH / 3 / 1  write address channel; AWPROT tied to 3'b000.
M_AXI_AWREADY  in  1  write address ready.
M_AXI_WDATA / WSTRB / WVALID  out  DATA_WIDTH / DATA_WIDTH/8 / 1  write data channel.
M_AXI_WREADY  in  1  write data ready.
M_AXI_BRESP / BVALID  in  2 / 1  write response.
M_AXI_BREADY  out  1  write response ready.
M_AXI_ARADDR / ARPROT / ARVALID  out  ADDR_WIDTH / 3 / 1  read address channel; ARPROT tied to 3'b000.
M_AXI_ARREADY  in  1  read address ready.
M_AXI_RDATA / RRESP / RVALID  in  DATA_WIDTH / 2 / 1  read data and response.
M_AXI_RREADY  out  1  read data ready.

Behaviour:
- Reset values (async on ARESET=1): state=IDLE, rr_ptr=0, and every VALID/READY output, rspN_valid, rspN_rdata and rspN_resp at 0. AXI address and data registers also reset to 0.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE, grant selection (combinational):
  - Only one reqN_valid high: that requester wins.
  - Both high: requester rr_ptr wins.
  - reqG_ready=1 for the winner only, and only while in IDLE.
- IDLE, on handshake: capture wr, addr, wdata and wstrb, and store the granted index G.
  - Next state is WR_ADDR_DATA if wr=1, otherwise RD_ADDR.
  - Uncaptured command fields must not change captured values.
- WR_ADDR_DATA:
  - AWVALID and WVALID rise together on entry.
  - Each drops the cycle after its own handshake, independently. The aw_done and w_done flags track completion.
  - Move to WR_RESP once both handshakes have occurred. Same-cycle handshakes are allowed.
- WR_RESP: BREADY=1. On BVALID, capture BRESP, set rdata=0, go to RESP.
- RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA and RRESP, go to RESP.
- RESP:
  - rspG_valid=1 for exactly one cycle with the captured data and response. No backpressure on the response.
  - Set rr_ptr = ~G, then return to IDLE.
- A new grant is possible on the cycle after RESP.
- Latency with a zero-wait slave (READYs tied high, B/R one cycle after the address):
  - Write: req handshake at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_valid at cycle 3.
  - Read: same timing, with AR at cycle 1 and R at cycle 2.
- VALID stability: AXI VALID signals and their payloads stay constant until their READY, per AXI4-Lite. The block never deasserts a VALID before its handshake.
- Only one outstanding transaction at a time. The block never issues AR while a write is in flight, or the reverse.
- Response codes (SLVERR/DECERR) pass through unmodified. The block does not retry.
- Reset mid-operation: all outputs return to their reset values immediately. Any in-flight transaction is abandoned with no response pulse. The slave shares this reset domain.
- Starvation: with both requesters continuously valid, grants alternate 0,1,0,1...

Test Plan:
- Write then read, req0: after reset, req0 writes addr 0x0, data 0x0101FFFF, wstrb 0xF -> one AW+W at 0x0, rsp0_resp=00. Read 0x0 -> rsp0_rdata=0x0101FFFF. rsp1_valid never pulses.
- Sweep, req1: writes 0xabcd0001, 0xdead0011, 0xbeef0011 to 0x4, 0x8, 0xC, each followed by a read -> each read returns the written value with resp 00. With a zero-wait slave, rsp_valid arrives exactly 3 cycles after each req handshake.
- Contention: req0 and req1 both valid at the first cycle after reset -> req0 served first, then req1. Holding both valid for 4 commands gives grant order 0,1,0,1.
- Backpressure: AWREADY held low 3 cycles, WREADY high immediately -> WVALID high for 1 cycle, AWVALID high for 4 cycles with a stable address, exactly one B accepted, one rsp pulse.
- Error passthrough: slave returns RRESP=2'b10 on a read of 0x10 -> rsp_resp=2'b10 and rsp_rdata equal to the slave's RDATA. rr_ptr still toggles.
- Reset mid-read: assert ARESET while in RD_DATA -> ARVALID, RREADY and rsp_valid are 0 within the same cycle. After release the arbiter accepts a new req0 command with rr_ptr=0.

Source files
------------

// File: rtl/cube_regbus_arbiter.sv
// cube_regbus_arbiter: round-robin arbiter sharing one AXI4-Lite master port between two
// single-beat register requesters, one transaction in flight at a time.
module cube_regbus_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic                      req0_wr,
    input  logic [ADDR_WIDTH-1:0]     req0_addr,
    input  logic [DATA_WIDTH-1:0]     req0_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req0_wstrb,
    output logic                      rsp0_valid,
    output logic [DATA_WIDTH-1:0]     rsp0_rdata,
    output logic [1:0]                rsp0_resp,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic                      req1_wr,
    input  logic [ADDR_WIDTH-1:0]     req1_addr,
    input  logic [DATA_WIDTH-1:0]     req1_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req1_wstrb,
    output logic                      rsp1_valid,
    output logic [DATA_WIDTH-1:0]     rsp1_rdata,
    output logic [1:0]                rsp1_resp,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;

    state_t                    state_q, state_d;
    logic                      rr_ptr_q, rr_ptr_d;
    logic                      g_q, g_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      sel1;
    logic                      any_req;

    // requester 1 wins when it is alone or when both are valid and it holds the pointer
    assign sel1    = req1_valid && (!req0_valid || rr_ptr_q);
    assign any_req = req0_valid || req1_valid;

    assign req0_ready = (state_q == IDLE) && req0_valid && !sel1;
    assign req1_ready = (state_q == IDLE) && sel1;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = (state_q == WR_ADDR_DATA) && !aw_done_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = (state_q == WR_ADDR_DATA) && !w_done_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = (state_q == RD_ADDR);
    assign M_AXI_RREADY  = (state_q == RD_DATA);

    assign rsp0_valid = (state_q == RESP) && !g_q;
    assign rsp1_valid = (state_q == RESP) && g_q;
    assign rsp0_rdata = rdata_q;
    assign rsp1_rdata = rdata_q;
    assign rsp0_resp  = resp_q;
    assign rsp1_resp  = resp_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        g_d       = g_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: if (any_req) begin
                g_d       = sel1;
                addr_d    = sel1 ? req1_addr : req0_addr;
                wdata_d   = sel1 ? req1_wdata : req0_wdata;
                wstrb_d   = sel1 ? req1_wstrb : req0_wstrb;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                state_d   = (sel1 ? req1_wr : req0_wr) ? WR_ADDR_DATA : RD_ADDR;
            end
            WR_ADDR_DATA: begin
                aw_done_d = aw_done_q || (M_AXI_AWVALID && M_AXI_AWREADY);
                w_done_d  = w_done_q || (M_AXI_WVALID && M_AXI_WREADY);
                state_d   = (aw_done_d && w_done_d) ? WR_RESP : WR_ADDR_DATA;
            end
            WR_RESP: if (M_AXI_BVALID) begin
                resp_d  = M_AXI_BRESP;
                rdata_d = '0;
                state_d = RESP;
            end
            RD_ADDR: state_d = M_AXI_ARREADY ? RD_DATA : RD_ADDR;
            RD_DATA: if (M_AXI_RVALID) begin
                resp_d  = M_AXI_RRESP;
                rdata_d = M_AXI_RDATA;
                state_d = RESP;
            end
            RESP: begin
                rr_ptr_d = ~g_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            g_q       <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            g_q       <= g_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end
endmodule
